// File: rtl/hash_window_match_dispatcher.sv
// ----------------------------------------------------------------------------
// hash_window_match_dispatcher
//
// Accepts one hash window per input handshake, filters out candidates that
// cannot produce a useful match, and serializes the surviving positions in
// ascending order as one match request per cycle. A window with no survivors
// still emits a single marker beat (output_req_valid=0), so window boundaries
// and delimiters always reach the match PEs.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   cfg_min_match_len           filter threshold, sampled at input acceptance
//   input_valid / input_ready   window handshake
//   input_head_addr             address of position 0
//   input_history_valid         per-position candidate present
//   input_history_addr          per-position candidate address (flattened)
//   input_meta_match_len        per-position pre-verified length (flattened)
//   input_meta_match_can_ext    per-position "may extend" flag
//   input_data                  window bytes (flattened)
//   input_delim                 window ends a block
//   output_valid / output_ready request handshake
//   output_req_valid            beat carries a real request
//   output_offset, output_addr  position within window, head_addr + offset
//   output_history_addr, output_meta_match_len,
//   output_meta_match_can_ext, output_data   fields of the selected position
//   output_last, output_delim   final beat of window, window delim on last beat
// ----------------------------------------------------------------------------
module hash_window_match_dispatcher #(
   parameter int HASH_ISSUE_WIDTH     = 32,
   parameter int ADDR_WIDTH           = 32,
   parameter int META_MATCH_LEN_WIDTH = 6,
   localparam int OFF_W               = $clog2(HASH_ISSUE_WIDTH)
) (
   input  logic                                          clk,
   input  logic                                          rst_n,
   input  logic [META_MATCH_LEN_WIDTH-1:0]               cfg_min_match_len,
   input  logic                                          input_valid,
   output logic                                          input_ready,
   input  logic [ADDR_WIDTH-1:0]                         input_head_addr,
   input  logic [HASH_ISSUE_WIDTH-1:0]                   input_history_valid,
   input  logic [HASH_ISSUE_WIDTH*ADDR_WIDTH-1:0]        input_history_addr,
   input  logic [HASH_ISSUE_WIDTH*META_MATCH_LEN_WIDTH-1:0] input_meta_match_len,
   input  logic [HASH_ISSUE_WIDTH-1:0]                   input_meta_match_can_ext,
   input  logic [HASH_ISSUE_WIDTH*8-1:0]                 input_data,
   input  logic                                          input_delim,
   output logic                                          output_valid,
   input  logic                                          output_ready,
   output logic                                          output_req_valid,
   output logic [OFF_W-1:0]                              output_offset,
   output logic [ADDR_WIDTH-1:0]                         output_addr,
   output logic [ADDR_WIDTH-1:0]                         output_history_addr,
   output logic [META_MATCH_LEN_WIDTH-1:0]               output_meta_match_len,
   output logic                                          output_meta_match_can_ext,
   output logic [7:0]                                    output_data,
   output logic                                          output_last,
   output logic                                          output_delim
);

   localparam int W = HASH_ISSUE_WIDTH;
   localparam int A = ADDR_WIDTH;
   localparam int M = META_MATCH_LEN_WIDTH;
   localparam logic [W-1:0] LSB_ONE = W'(1);

   // Window buffer
   logic                 full;
   logic [W-1:0]         pending;
   logic [A-1:0]         head_q;
   logic [W*A-1:0]       hist_q;
   logic [W*M-1:0]       mlen_q;
   logic [W-1:0]         cext_q;
   logic [W*8-1:0]       data_q;
   logic                 delim_q;

   logic [W-1:0]         keep;
   logic [W-1:0]         sel_onehot;
   logic [OFF_W-1:0]     sel;
   logic                 any_pending;
   logic                 single_left;
   logic                 out_hs;
   logic                 in_hs;

   always_comb begin
      keep = '0;
      for (int unsigned i = 0; i < W; i++) begin
         keep[i] = input_history_valid[i] &
                   (input_meta_match_can_ext[i] |
                    (input_meta_match_len[i*M +: M] >= cfg_min_match_len));
      end
   end

   // Lowest set bit of pending, both as a one-hot mask and as an index.
   assign sel_onehot = pending & (~pending + LSB_ONE);

   always_comb begin
      sel = '0;
      for (int unsigned i = W; i > 0; i--) begin
         if (pending[i-1]) sel = OFF_W'(i - 1);
      end
   end

   assign any_pending = |pending;
   // popcount(pending) <= 1: clearing the lowest set bit leaves nothing.
   assign single_left = ((pending & (pending - LSB_ONE)) == '0);

   assign output_valid = full;
   assign out_hs       = full & output_ready;
   assign input_ready  = ~full | (out_hs & single_left);
   assign in_hs        = input_valid & input_ready;

   // Outputs are a pure mux of registered state; with pending empty the
   // beat is the empty-window marker (sel=0, so addr=head_addr).
   always_comb begin
      output_req_valid          = 1'b0;
      output_offset             = '0;
      output_addr               = '0;
      output_history_addr       = '0;
      output_meta_match_len     = '0;
      output_meta_match_can_ext = 1'b0;
      output_data               = '0;
      output_last               = 1'b0;
      output_delim              = 1'b0;
      if (full) begin
         output_offset = sel;
         output_addr   = head_q + A'(sel);
         output_last   = single_left;
         output_delim  = single_left & delim_q;
         if (any_pending) begin
            output_req_valid          = 1'b1;
            output_history_addr       = hist_q[sel*A +: A];
            output_meta_match_len     = mlen_q[sel*M +: M];
            output_meta_match_can_ext = cext_q[sel];
            output_data               = data_q[sel*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         full    <= 1'b0;
         pending <= '0;
         head_q  <= '0;
         hist_q  <= '0;
         mlen_q  <= '0;
         cext_q  <= '0;
         data_q  <= '0;
         delim_q <= 1'b0;
      end else if (in_hs) begin
         // Covers both EMPTY->FULL and the same-cycle last-beat reload.
         full    <= 1'b1;
         pending <= keep;
         head_q  <= input_head_addr;
         hist_q  <= input_history_addr;
         mlen_q  <= input_meta_match_len;
         cext_q  <= input_meta_match_can_ext;
         data_q  <= input_data;
         delim_q <= input_delim;
      end else if (out_hs) begin
         pending <= pending & ~sel_onehot;
         if (single_left) full <= 1'b0;
      end
   end

endmodule
